sprite_fetch_arbiter: RTL and testbench



---
 rtl/sprite_fetch_arbiter.sv | 117 +++++++++++
 tb/tb_sprite_fetch_arbiter.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/sprite_fetch_arbiter.sv
// Round-robin arbiter sharing one sprite RAM read port; SPRITE_ARB_PRIO0_EN gives requester 0 fixed top priority.
// Latency: grant cycle N -> rsp_valid/rsp_data registered in cycle N+RD_LAT+1, one grant per cycle.
// Backpressure: req_ready is a combinational one-hot grant; ungranted requesters hold valid and address.
module sprite_fetch_arbiter #(
  parameter int NREQ   = 4,
  parameter int ADDR_W = 12,
  parameter int DATA_W = 24,
  parameter int RD_LAT = 1
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  output logic [NREQ-1:0]        req_ready,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic                   mem_rd_en,
  input  logic [DATA_W-1:0]      mem_data,
  output logic [NREQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]      rsp_data,
  output logic                   busy
);

  localparam int IDX_W = $clog2(NREQ);

  // Modulo-NREQ increment that also wraps correctly for non-power-of-two NREQ.
  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] base, input int step);
    int sum;
    sum = int'(base) + step;
    if (sum >= NREQ) sum = sum - NREQ;
    return sum[IDX_W-1:0];
  endfunction

  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] grant_idx;
  logic [IDX_W-1:0] cand;
  logic             grant_found;

  logic [RD_LAT-1:0] pipe_vld;
  logic [NREQ-1:0]   pipe_id [RD_LAT];

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
`ifdef SPRITE_ARB_PRIO0_EN
    if (req_valid[0]) begin
      grant_found = 1'b1;
    end
    // Requester 0 is excluded from the rotation; it never waits on rr_ptr.
    for (int k = 0; k < NREQ; k++) begin
      cand = wrap_inc(rr_ptr, k);
      if (!grant_found && cand != '0 && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
`else
    for (int k = 0; k < NREQ; k++) begin
      cand = wrap_inc(rr_ptr, k);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
`endif
    if (Reset) grant_found = 1'b0;
  end

  always_comb begin
    req_ready = '0;
    mem_addr  = '0;
    mem_rd_en = 1'b0;
    if (grant_found) begin
      req_ready[grant_idx] = 1'b1;
      mem_addr             = req_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
      mem_rd_en            = 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      rr_ptr <= '0;
    end else if (grant_found) begin
`ifdef SPRITE_ARB_PRIO0_EN
      if (grant_idx != '0) rr_ptr <= wrap_inc(grant_idx, 1);
`else
      rr_ptr <= wrap_inc(grant_idx, 1);
`endif
    end
  end

  // Tag pipeline tracks the RAM latency so data and requester id line up.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      pipe_vld  <= '0;
      for (int s = 0; s < RD_LAT; s++) pipe_id[s] <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
    end else begin
      pipe_vld[0] <= grant_found;
      pipe_id[0]  <= req_ready;
      for (int s = 1; s < RD_LAT; s++) begin
        pipe_vld[s] <= pipe_vld[s-1];
        pipe_id[s]  <= pipe_id[s-1];
      end
      if (pipe_vld[RD_LAT-1]) begin
        rsp_valid <= pipe_id[RD_LAT-1];
        rsp_data  <= mem_data;
      end else begin
        rsp_valid <= '0;
      end
    end
  end

  assign busy = (|pipe_vld) | (|rsp_valid);

endmodule

// File: tb/tb_sprite_fetch_arbiter.sv
// Scoreboard bench: one RD_LAT=1 instance and one RD_LAT=3 instance, each with a sync RAM model.
module tb_sprite_fetch_arbiter;

`ifdef SPRITE_ARB_PRIO0_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  localparam logic [47:0] ADDRS = {12'h3C4, 12'h2A3, 12'h111, 12'h100};

  typedef struct {
    logic [3:0]  id;
    logic [23:0] data;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic Reset;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  bit   mon_en;
  bit   ram_const;

  logic [3:0]  rv1, rdy1, rspv1, rv3, rdy3, rspv3;
  logic [47:0] ra1, ra3;
  logic [11:0] maddr1, maddr3;
  logic        rd1, rd3, busy1, busy3;
  logic [23:0] md1, md3, rspd1, rspd3;
  logic [23:0] p3 [3];

  exp_t q1[$];
  exp_t q3[$];
  exp_t e1, e3;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sprite_fetch_arbiter #(.NREQ(4), .ADDR_W(12), .DATA_W(24), .RD_LAT(1)) dut1 (
    .Clk(clk), .Reset(Reset), .req_valid(rv1), .req_addr(ra1), .req_ready(rdy1),
    .mem_addr(maddr1), .mem_rd_en(rd1), .mem_data(md1), .rsp_valid(rspv1),
    .rsp_data(rspd1), .busy(busy1));

  sprite_fetch_arbiter #(.NREQ(4), .ADDR_W(12), .DATA_W(24), .RD_LAT(3)) dut3 (
    .Clk(clk), .Reset(Reset), .req_valid(rv3), .req_addr(ra3), .req_ready(rdy3),
    .mem_addr(maddr3), .mem_rd_en(rd3), .mem_data(md3), .rsp_valid(rspv3),
    .rsp_data(rspd3), .busy(busy3));

  function automatic logic [23:0] ram_word(input logic [11:0] a);
    return {a ^ 12'h5A5, a};
  endfunction

  always @(posedge clk) md1 <= ram_const ? 24'h47B7AE : ram_word(maddr1);

  always @(posedge clk) begin
    p3[0] <= ram_word(maddr3);
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign md3 = p3[2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (q1.size() > 0 && q1[0].due == cyc) begin
        e1 = q1.pop_front();
        check("rsp1_valid", rspv1, e1.id);
        check("rsp1_data", rspd1, e1.data);
      end else begin
        check("rsp1_idle", rspv1, 0);
      end
      if (q3.size() > 0 && q3[0].due == cyc) begin
        e3 = q3.pop_front();
        check("rsp3_valid", rspv3, e3.id);
        check("rsp3_data", rspd3, e3.data);
      end else begin
        check("rsp3_idle", rspv3, 0);
      end
    end
  end

  // One cycle of stimulus; exp_busy < 0 means busy is not checked this cycle.
  task automatic step(input bit sel, input logic [3:0] rv, input logic [47:0] ra,
                      input logic [3:0] exp_rdy, input int exp_busy);
    logic [11:0] ea;
    exp_t        e;
    ea = '0;
    for (int i = 0; i < 4; i++) if (exp_rdy[i]) ea = ra[i*12 +: 12];
    if (!sel) begin
      rv1 = rv; ra1 = ra; rv3 = '0;
    end else begin
      rv3 = rv; ra3 = ra; rv1 = '0;
    end
    @(negedge clk);
    if (!sel) begin
      check("req_ready1", rdy1, exp_rdy);
      check("mem_addr1", maddr1, ea);
      check("mem_rd_en1", rd1, |exp_rdy);
      if (exp_busy >= 0) check("busy1", busy1, exp_busy);
      if (exp_rdy != 0) begin
        e.id = exp_rdy; e.data = ram_const ? 24'h47B7AE : ram_word(ea); e.due = cyc + 2;
        q1.push_back(e);
      end
    end else begin
      check("req_ready3", rdy3, exp_rdy);
      check("mem_addr3", maddr3, ea);
      check("mem_rd_en3", rd3, |exp_rdy);
      if (exp_busy >= 0) check("busy3", busy3, exp_busy);
      if (exp_rdy != 0) begin
        e.id = exp_rdy; e.data = ram_word(ea); e.due = cyc + 4;
        q3.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    Reset = 1'b1; rv1 = '0; ra1 = '0; rv3 = '0; ra3 = '0;
    ram_const = 1'b1; mon_en = 1'b0;
    @(posedge clk);
    #1;
    step(0, 4'hF, ADDRS, 4'h0, -1);
    step(0, 4'hF, ADDRS, 4'h0, -1);
    Reset = 1'b0; mon_en = 1'b1;
    step(0, 4'h0, ADDRS, 4'h0, 0);

    // single requester, back-to-back grants with constant RAM word
    repeat (3) step(0, 4'b0100, ADDRS, 4'b0100, -1);
    repeat (3) step(0, 4'b0000, ADDRS, 4'b0000, -1);
    step(0, 4'b0000, ADDRS, 4'b0000, 0);
    ram_const = 1'b0;

    // wrap from rr_ptr=3 and skip idle requesters
    step(0, 4'b0011, ADDRS, 4'b0001, -1);
    step(0, 4'b0010, ADDRS, 4'b0010, -1);
    step(0, 4'b1111, ADDRS, PRIO ? 4'b0001 : 4'b0100, -1);
    step(0, 4'b1110, ADDRS, PRIO ? 4'b0100 : 4'b1000, -1);
    repeat (2) step(0, 4'b0000, ADDRS, 4'b0000, -1);

    Reset = 1'b1; q1.delete(); q3.delete();
    step(0, 4'hF, ADDRS, 4'h0, -1);
    Reset = 1'b0;

    // full contention from rr_ptr=0
    for (int k = 0; k < 8; k++)
      step(0, 4'b1111, ADDRS, PRIO ? 4'b0001 : 4'(1 << (k % 4)), -1);

    // requester 0 priority (or plain rotation) then rotation among 1 and 3
    for (int k = 0; k < 3; k++)
      step(0, 4'b1011, ADDRS, PRIO ? 4'b0001 : (k == 0 ? 4'b0001 : (k == 1 ? 4'b0010 : 4'b1000)), -1);
    for (int k = 0; k < 4; k++)
      step(0, 4'b1010, ADDRS, (k % 2 == 0) ? 4'b0010 : 4'b1000, -1);
    repeat (2) step(0, 4'b0000, ADDRS, 4'b0000, -1);

    // reset one cycle after a grant drops the in-flight read
    step(0, 4'b0010, ADDRS, 4'b0010, -1);
    Reset = 1'b1; q1.delete();
    step(0, 4'b1111, ADDRS, 4'b0000, 1);
    Reset = 1'b0;
    step(0, 4'b0000, ADDRS, 4'b0000, 0);
    step(0, 4'b1111, ADDRS, 4'b0001, -1);
    repeat (2) step(0, 4'b0000, ADDRS, 4'b0000, -1);
    step(0, 4'b0000, ADDRS, 4'b0000, 0);

    // RD_LAT=3 continuous requests with per-cycle addresses
    for (int k = 0; k < 12; k++)
      step(1, 4'b1111, {12'h300 + 12'(k), 12'h200 + 12'(k), 12'h100 + 12'(k), 12'(k)},
           PRIO ? 4'b0001 : 4'(1 << (k % 4)), -1);
    repeat (4) step(1, 4'b0000, 48'h0, 4'b0000, -1);
    step(1, 4'b0000, 48'h0, 4'b0000, 0);

    check("queues_drained", q1.size() + q3.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
